uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver for the system's RX path.
- Configurable data width, oversampling ratio, parity and 1/2 stop bits.
- 3-sample majority vote per bit.
- Glitch-rejecting start detect and back-to-back frame support.
- Delivers a parallel word with a one-cycle valid strobe and per-frame error flags to the system control FSM.

Parameters:
DATA_W, 8, data bits per frame (5..9)
PRSC_W, 6, width of prescale input; max ratio 2^PRSC_W-2

Ports:
CLK  in  1  receiver oversampling clock
RST  in  1  synchronous active-low reset
RX_IN  in  1  serial line, idle high
prescale  in  PRSC_W  oversampling ratio; even, >=4
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
STP2  in  1  1 = two stop bits
P_DATA  out  DATA_W  received word, LSB first on line
Data_valid  out  1  one-cycle strobe, frame good
parity_error  out  1  one-cycle strobe, parity mismatch
framing_error  out  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset: one clock; synchronous, active-low (RST=0 sampled on CLK edge). Reset values: state IDLE, counters 0, P_DATA=0, all strobes 0.
- Reset mid-frame: abort to IDLE in the same edge; no strobe emitted.
- Config latch: prescale, PAR_EN, PAR_TYP and STP2 latched on the IDLE->START transition. Changes mid-frame are ignored.
- Edge counter: runs 0..prescale-1 per bit. Bit counter advances when edge_cnt == prescale-1.
- Sampling: samples taken at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1. Bit value is the 2-of-3 majority, registered at edge_cnt = prescale/2+2.
- FSM states and transitions:
  - IDLE: RX_IN==0 -> START, edge_cnt=0.
  - START: majority==1 at decision point -> IDLE (glitch; no strobes). Otherwise -> DATA at bit end.
  - DATA: shift right into a DATA_W shift register, LSB first. After DATA_W bits -> PARITY if latched PAR_EN, else STOP.
  - PARITY: expected bit = XOR(data) XOR PAR_TYP. Mismatch sets an internal par_flag.
  - STOP: majority==0 sets stp_flag. If STP2, a second STOP bit is checked identically and ORs into stp_flag.
  - DONE (1 cycle): emit strobes. Data_valid = !(par_flag|stp_flag); parity_error = par_flag; framing_error = stp_flag.
  - From DONE: RX_IN==0 -> START directly, else IDLE.
- Frame-end timing: the stop decision is made at mid-stop; DONE follows on the next cycle. The remaining half stop bit is not waited for, which allows back-to-back frames.
- Latency: Data_valid asserts prescale/2+3 cycles after the first falling edge of the (last) stop-bit period.
- P_DATA: updated only in the DONE cycle of a valid frame, together with Data_valid; otherwise it holds its value. Error frames leave P_DATA unchanged.
- Strobe exclusivity: Data_valid and error strobes are mutually exclusive. parity_error and framing_error may assert together.
- Illegal prescale (odd or <4): behaviour undefined; the verification bench must not drive it.
- Widths: edge_cnt is PRSC_W bits; bit counter is clog2(DATA_W+4) bits.

Optional Feature:
RX_SYNC_EN
- Defined: RX_IN passes through a 2-flop synchroniser reset to 1. All timing shifts later by 2 cycles; start detect uses the synchronised signal.
- Undefined: RX_IN is used directly and is assumed already synchronous to CLK.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, STOP2, DONE), constant MIN_PRESCALE=4, and a function for bit-counter width.
- One natural sub-module: uart_rx_sampler (edge counter + 3-sample majority + sample-done pulse), instantiated once. The FSM, shift register and checks stay in the top.

Test Plan:
- DATA_W=8, prescale=8, no parity, 1 stop, send 0xA5 -> one Data_valid pulse, P_DATA=0xA5, both error strobes 0.
- prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 1 -> parity_error pulse, Data_valid 0, P_DATA keeps its previous value.
- STP2=1, send 0x5A with second stop bit driven low -> framing_error pulse only.
- Start glitch: RX_IN low for 2 cycles at prescale=8 -> FSM back in IDLE, no strobes; a following valid frame 0x81 is received correctly.
- Two back-to-back frames 0x12 then 0x34 with no idle gap -> two Data_valid pulses with P_DATA 0x12 then 0x34. Also assert RST=0 mid-second-frame -> no further strobe, outputs reset.
- DATA_W=9, prescale=32, odd parity, send 0x1FF with correct parity bit -> P_DATA=0x1FF, Data_valid pulse. Majority check: a single-cycle flip on the middle sample is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding, prescale floor and the
// bit-counter width helper shared by the UART RX files.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5,
        DONE   = 3'd6
    } rx_state_e;

    localparam int MIN_PRESCALE = 4;

    function automatic int bcnt_w(input int dw);
        return $clog2(dw + 4);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, three mid-bit samples and
// a 2-of-3 majority vote.
// Ports: clk_i, rst_ni (sync, active-low), run_i (count while high,
// else hold at 0), prescale_i (latched ratio), rx_i (serial line),
// sample_done_o (1-cycle pulse, bit_o valid), bit_o (majority).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRSC_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [PRSC_W-1:0] prescale_i,
    input  logic              rx_i,
    output logic              sample_done_o,
    output logic              bit_o
);

    localparam logic [PRSC_W-1:0] ONE = PRSC_W'(1);

    logic [PRSC_W-1:0] cnt_q, cnt_d;
    logic [PRSC_W-1:0] half;
    logic [2:0]        smp_q, smp_d;
    logic              done_q, done_d;

    assign half = {1'b0, prescale_i[PRSC_W-1:1]};

    // The done pulse is the cycle after the third sample, so the vote
    // is always complete even when the window wraps into the next bit.
    always_comb begin
        cnt_d  = '0;
        smp_d  = smp_q;
        done_d = 1'b0;
        if (run_i) begin
            if (cnt_q == prescale_i - ONE) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
            if (cnt_q == half - ONE) begin
                smp_d[0] = rx_i;
            end
            if (cnt_q == half) begin
                smp_d[1] = rx_i;
            end
            if (cnt_q == half + ONE) begin
                smp_d[2] = rx_i;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            smp_q  <= '1;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            smp_q  <= smp_d;
            done_q <= done_d;
        end
    end

    assign sample_done_o = done_q;
    assign bit_o = (smp_q[0] & smp_q[1]) |
                   (smp_q[0] & smp_q[2]) |
                   (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (data width, ratio, parity,
// 1/2 stop bits) with glitch-rejecting start and back-to-back frames.
// Ports: CLK, RST (sync, active-low), RX_IN (idle high), prescale,
// PAR_EN, PAR_TYP (1=odd), STP2; P_DATA word, Data_valid,
// parity_error, framing_error (one-cycle strobes).
// Option: define RX_SYNC_EN to put a 2-flop synchroniser on RX_IN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PRSC_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [PRSC_W-1:0] prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STP2,
    output logic [DATA_W-1:0] P_DATA,
    output logic              Data_valid,
    output logic              parity_error,
    output logic              framing_error
);

    localparam int BCW = bcnt_w(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] BONE = BCW'(1);

    logic rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    rx_state_e         state_q, state_d;
    logic [PRSC_W-1:0] prsc_q, prsc_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              stp2_q, stp2_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              pf_q, pf_d;
    logic              sf_q, sf_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;

    logic run;
    logic sdone;
    logic smp_bit;
    logic start_det;
    logic finish;

    assign run = (state_q != IDLE) && (state_q != DONE);

    uart_rx_sampler #(
        .PRSC_W(PRSC_W)
    ) u_sampler (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .run_i        (run),
        .prescale_i   (prsc_q),
        .rx_i         (rx_s),
        .sample_done_o(sdone),
        .bit_o        (smp_bit)
    );

    always_comb begin
        state_d   = state_q;
        prsc_d    = prsc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stp2_d    = stp2_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        pf_d      = pf_q;
        sf_d      = sf_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
        start_det = 1'b0;
        finish    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (sdone) begin
                    state_d = smp_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sdone) begin
                    sh_d = {smp_bit, sh_q[DATA_W-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BONE;
                    end
                end
            end
            PARITY: begin
                if (sdone) begin
                    if (smp_bit != (^sh_q ^ par_typ_q)) begin
                        pf_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sdone) begin
                    sf_d = sf_q | ~smp_bit;
                    if (stp2_q) begin
                        state_d = STOP2;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (sdone) begin
                    sf_d   = sf_q | ~smp_bit;
                    finish = 1'b1;
                end
            end
            DONE: begin
                if (!rx_s) begin
                    state_d   = START;
                    start_det = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered on the stop decision so they appear
        // exactly in the DONE cycle.
        if (finish) begin
            state_d = DONE;
            dv_d    = ~(pf_q | sf_d);
            pe_d    = pf_q;
            fe_d    = sf_d;
            if (dv_d) begin
                pdata_d = sh_q;
            end
        end

        if (start_det) begin
            prsc_d    = prescale;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            stp2_d    = STP2;
            bit_cnt_d = '0;
            pf_d      = 1'b0;
            sf_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            prsc_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stp2_q    <= 1'b0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            pf_q      <= 1'b0;
            sf_q      <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            prsc_q    <= prsc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stp2_q    <= stp2_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            pf_q      <= pf_d;
            sf_q      <= sf_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
        end
    end

    assign P_DATA        = pdata_q;
    assign Data_valid    = dv_q;
    assign parity_error  = pe_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into an 8-bit and a 9-bit receiver
// with hand-computed expected words, strobes and latencies.
module tb_uart_rx_cfg;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] prescale;
    logic       PAR_EN, PAR_TYP, STP2;
    logic       rx8, rx9;
    logic [7:0] pd8;
    logic       dv8, pe8, fe8;
    logic [8:0] pd9;
    logic       dv9, pe9, fe9;

    always #5 CLK = ~CLK;

    uart_rx_cfg #(.DATA_W(8), .PRSC_W(6)) u8 (
        .CLK(CLK), .RST(RST), .RX_IN(rx8), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2),
        .P_DATA(pd8), .Data_valid(dv8),
        .parity_error(pe8), .framing_error(fe8)
    );

    uart_rx_cfg #(.DATA_W(9), .PRSC_W(6)) u9 (
        .CLK(CLK), .RST(RST), .RX_IN(rx9), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2),
        .P_DATA(pd9), .Data_valid(dv9),
        .parity_error(pe9), .framing_error(fe9)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int dv8_n = 0, pe8_n = 0, fe8_n = 0;
    int dv9_n = 0, pe9_n = 0, fe9_n = 0;
    int dv_cyc8 = 0, dv_cyc9 = 0;
    int excl = 0;
    logic [7:0] dq8[$];

    always @(negedge CLK) begin
        if (dv8) begin
            dv8_n++;
            dq8.push_back(pd8);
            dv_cyc8 = cyc;
        end
        if (pe8) pe8_n++;
        if (fe8) fe8_n++;
        if (dv9) begin
            dv9_n++;
            dv_cyc9 = cyc;
        end
        if (pe9) pe9_n++;
        if (fe9) fe9_n++;
        if ((dv8 && (pe8 || fe8)) || (dv9 && (pe9 || fe9))) excl++;
    end

    // Frame bits LSB first: start, data, [parity], stop, [stop2].
    task automatic mk(input logic [8:0] d, input int dw, input bit pe,
                      input bit pb, input int ns, input bit s2v,
                      output logic [15:0] bits, output int n);
        int idx;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < dw; i++) bits[1+i] = d[i];
        idx = 1 + dw;
        if (pe) begin
            bits[idx] = pb;
            idx++;
        end
        bits[idx] = 1'b1;
        idx++;
        if (ns == 2) begin
            bits[idx] = s2v;
            idx++;
        end
        n = idx;
    endtask

    // Called on a negedge; the next posedge is the first start-bit edge.
    task automatic send(input bit which, input logic [15:0] bits,
                        input int n, input int p, input int gbit,
                        input int gcyc, output int t0);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < p; c++) begin
                logic b;
                b = bits[i];
                if (i == gbit && c == gcyc) b = ~b;
                if (which) rx9 = b;
                else rx8 = b;
                @(negedge CLK);
            end
        end
        rx8 = 1'b1;
        rx9 = 1'b1;
    endtask

    logic [15:0] bits;
    int n, t0, tx;
    int b_dv, b_pe, b_fe;

    task automatic snap8();
        b_dv = dv8_n;
        b_pe = pe8_n;
        b_fe = fe8_n;
    endtask

    initial begin
        RST = 1'b0;
        prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STP2 = 1'b0;
        rx8 = 1'b1;
        rx9 = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_pd8", pd8, 0);
        chk("rst_st8", {dv8, pe8, fe8}, 0);
        chk("rst_pd9", pd9, 0);
        chk("rst_st9", {dv9, pe9, fe9}, 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5, p=8, no parity, 1 stop; dv at 1+9*8+4+3 = 80
        snap8();
        mk(9'h0A5, 8, 0, 0, 1, 1, bits, n);
        send(0, bits, n, 8, -1, 0, t0);
        repeat (16) @(negedge CLK);
        chk("t1_dv", dv8_n - b_dv, 1);
        chk("t1_pd", pd8, 8'hA5);
        chk("t1_err", (pe8_n - b_pe) + (fe8_n - b_fe), 0);
        chk("t1_lat", dv_cyc8 - t0, 80);

        // 0x3C, p=16, even parity, parity bit 1 -> parity error
        snap8();
        prescale = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        mk(9'h03C, 8, 1, 1, 1, 1, bits, n);
        send(0, bits, n, 16, -1, 0, t0);
        repeat (32) @(negedge CLK);
        chk("t2_pe", pe8_n - b_pe, 1);
        chk("t2_dv", dv8_n - b_dv, 0);
        chk("t2_fe", fe8_n - b_fe, 0);
        chk("t2_pd", pd8, 8'hA5);

        // 0x5A, p=8, two stops, second stop low -> framing error
        snap8();
        prescale = 6'd8;
        PAR_EN = 1'b0;
        STP2 = 1'b1;
        mk(9'h05A, 8, 0, 0, 2, 0, bits, n);
        send(0, bits, n, 8, -1, 0, t0);
        repeat (16) @(negedge CLK);
        chk("t3_fe", fe8_n - b_fe, 1);
        chk("t3_pe", pe8_n - b_pe, 0);
        chk("t3_dv", dv8_n - b_dv, 0);
        chk("t3_pd", pd8, 8'hA5);

        // 2-cycle start glitch, then a good 0x81
        snap8();
        STP2 = 1'b0;
        rx8 = 1'b0;
        repeat (2) @(negedge CLK);
        rx8 = 1'b1;
        repeat (20) @(negedge CLK);
        chk("t4_glitch",
            (dv8_n - b_dv) + (pe8_n - b_pe) + (fe8_n - b_fe), 0);
        mk(9'h081, 8, 0, 0, 1, 1, bits, n);
        send(0, bits, n, 8, -1, 0, t0);
        repeat (16) @(negedge CLK);
        chk("t4_dv", dv8_n - b_dv, 1);
        chk("t4_pd", pd8, 8'h81);

        // back-to-back 0x12, 0x34, then reset inside a third frame
        snap8();
        dq8.delete();
        mk(9'h012, 8, 0, 0, 1, 1, bits, n);
        send(0, bits, n, 8, -1, 0, t0);
        mk(9'h034, 8, 0, 0, 1, 1, bits, n);
        send(0, bits, n, 8, -1, 0, t0);
        mk(9'h0FF, 8, 0, 0, 1, 1, bits, n);
        fork
            send(0, bits, n, 8, -1, 0, tx);
            begin
                repeat (30) @(negedge CLK);
                RST = 1'b0;
                @(negedge CLK);
                chk("t5_rst_pd", pd8, 0);
                RST = 1'b1;
            end
        join
        repeat (24) @(negedge CLK);
        chk("t5_dv", dv8_n - b_dv, 2);
        chk("t5_nq", dq8.size(), 2);
        if (dq8.size() == 2) begin
            chk("t5_w0", dq8[0], 8'h12);
            chk("t5_w1", dq8[1], 8'h34);
        end
        chk("t5_err", (pe8_n - b_pe) + (fe8_n - b_fe), 0);
        chk("t5_pd", pd8, 0);

        // 9-bit 0x1FF, p=32, odd parity bit 0, middle-sample flip on
        // data bit 4; dv at 1+11*32+16+3 = 372
        b_dv = dv9_n;
        b_pe = pe9_n;
        b_fe = fe9_n;
        prescale = 6'd32;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
        mk(9'h1FF, 9, 1, 0, 1, 1, bits, n);
        send(1, bits, n, 32, 5, 17, t0);
        repeat (48) @(negedge CLK);
        chk("t6_dv", dv9_n - b_dv, 1);
        chk("t6_pd", pd9, 9'h1FF);
        chk("t6_err", (pe9_n - b_pe) + (fe9_n - b_fe), 0);
        chk("t6_lat", dv_cyc9 - t0, 372);

        chk("excl", excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
